// File: rtl/pc_next_unit.sv
// Next-PC selection (PC+4 or PC+4+offset) and the PC register, with redirect capture across stalls.
// Latency: a taken jump/branch lands on PC one cycle after decode; a stalled one on the posedge after BUSYWAIT falls.
// Backpressure: BUSYWAIT freezes PC; the first-stall-cycle decision is held and applied on release.
module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             BUSYWAIT,
  input  logic             JUMP,
  input  logic             BRANCH,
  input  logic             BNE,
  input  logic             ZERO,
  input  logic [31:0]      OFFSET_EXT,
  output logic [31:0]      PC,
  output logic [31:0]      PC_PLUS4,
  output logic             REDIRECT,
  output logic             FETCH_EN,
  output logic [CNT_W-1:0] STALL_CNT
);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_STALL = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] hold_pc;
  logic        hold_take;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        take;
  logic [31:0] pc_d;
  logic [31:0] hold_pc_d;
  logic        hold_take_d;
  logic        redirect_d;

  // All adds wrap at 2^32; the offset only reaches PC through the TAKE mux,
  // so an undefined offset on a not-taken instruction never lands on PC.
  assign PC_PLUS4 = PC + 32'd4;
  assign target   = PC_PLUS4 + OFFSET_EXT;
  assign take     = JUMP | (BRANCH & ZERO) | (BNE & ~ZERO);
  assign next_pc  = take ? target : PC_PLUS4;
  assign FETCH_EN = (state == S_RUN) && !BUSYWAIT;

  // Next-state and next-register values; controls are sampled only in RUN,
  // so inputs that change during an ongoing stall are ignored.
  always_comb begin
    state_nxt   = state;
    pc_d        = PC;
    hold_pc_d   = hold_pc;
    hold_take_d = hold_take;
    redirect_d  = 1'b0;
    case (state)
      S_RUN: begin
        if (BUSYWAIT) begin
          hold_pc_d   = next_pc;
          hold_take_d = take;
          state_nxt   = S_STALL;
        end else begin
          pc_d       = next_pc;
          redirect_d = take;
        end
      end
      S_STALL: begin
        if (!BUSYWAIT) begin
          pc_d       = hold_pc;
          redirect_d = hold_take;
          state_nxt  = S_RUN;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // State and PC registers; reset drops any captured redirect.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_RUN;
      PC        <= RESET_PC;
      hold_pc   <= 32'h0;
      hold_take <= 1'b0;
      REDIRECT  <= 1'b0;
    end else begin
      state     <= state_nxt;
      PC        <= pc_d;
      hold_pc   <= hold_pc_d;
      hold_take <= hold_take_d;
      REDIRECT  <= redirect_d;
    end
  end

  // Stall-cycle counter, saturating at all-ones.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      STALL_CNT <= '0;
    end else if (BUSYWAIT && (STALL_CNT != CNT_MAX)) begin
      STALL_CNT <= STALL_CNT + 1'b1;
    end
  end

endmodule
